point_sequencer: RTL and testbench

POINT_SEQUENCER -- requirements
Module: point_sequencer

---
 rtl/point_sequencer_if.sv | 26 ++
 rtl/point_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_point_sequencer.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/point_sequencer_if.sv
// Handshake bundle between point_sequencer (master) and the update_point engine (slave).
interface point_sequencer_if #(
   parameter int POSITION_SIZE = 8,
   parameter int VELOCITY_SIZE = 8
);
   logic                     begin_out;
   logic [POSITION_SIZE-1:0] pos_x_out;
   logic [POSITION_SIZE-1:0] pos_y_out;
   logic [VELOCITY_SIZE-1:0] vel_x_out;
   logic [VELOCITY_SIZE-1:0] vel_y_out;
   logic [POSITION_SIZE-1:0] new_pos_x_in;
   logic [POSITION_SIZE-1:0] new_pos_y_in;
   logic [VELOCITY_SIZE-1:0] new_vel_x_in;
   logic [VELOCITY_SIZE-1:0] new_vel_y_in;
   logic                     result_in;

   modport master (
      output begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out,
      input  new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in, result_in
   );

   modport slave (
      input  begin_out, pos_x_out, pos_y_out, vel_x_out, vel_y_out,
      output new_pos_x_in, new_pos_y_in, new_vel_x_in, new_vel_y_in, result_in
   );
endinterface

// File: rtl/point_sequencer.sv
// Holds NUM_POINTS soft-body points and walks them through update_point once per frame.
// Optional macro SEQ_TIMEOUT_EN adds a per-point WAIT timeout and the sticky timeout_out flag.
module point_sequencer #(
   parameter int NUM_POINTS     = 4,
   parameter int POSITION_SIZE  = 8,
   parameter int VELOCITY_SIZE  = 8,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     frame_start_in,
   input  logic                     init_valid_in,
   input  logic [7:0]               init_idx_in,
   input  logic [POSITION_SIZE-1:0] init_pos_x_in,
   input  logic [POSITION_SIZE-1:0] init_pos_y_in,
   input  logic [VELOCITY_SIZE-1:0] init_vel_x_in,
   input  logic [VELOCITY_SIZE-1:0] init_vel_y_in,
   point_sequencer_if.master        upd,
   input  logic [7:0]               rd_idx_in,
   output logic [POSITION_SIZE-1:0] rd_pos_x_out,
   output logic [POSITION_SIZE-1:0] rd_pos_y_out,
   output logic                     busy_out,
   output logic                     frame_done_out,
   output logic                     timeout_out
);

   localparam int PW = POSITION_SIZE;
   localparam int VW = VELOCITY_SIZE;
   localparam logic [7:0] LAST_IDX = 8'(NUM_POINTS - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   if (NUM_POINTS < 1 || NUM_POINTS > 256 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("point_sequencer: NUM_POINTS must be 1..256 and TIMEOUT_CYCLES >= 1");
   end

   logic [1:0]    state_q, state_d;
   logic [7:0]    idx_q, idx_d;
   logic          busy_q, busy_d;

   logic [PW-1:0] pos_x_q [NUM_POINTS];
   logic [PW-1:0] pos_x_d [NUM_POINTS];
   logic [PW-1:0] pos_y_q [NUM_POINTS];
   logic [PW-1:0] pos_y_d [NUM_POINTS];
   logic [VW-1:0] vel_x_q [NUM_POINTS];
   logic [VW-1:0] vel_x_d [NUM_POINTS];
   logic [VW-1:0] vel_y_q [NUM_POINTS];
   logic [VW-1:0] vel_y_d [NUM_POINTS];

   // Last value presented to update_point; shown on the outputs outside ISSUE/WAIT.
   logic [PW-1:0] held_pos_x_q, held_pos_x_d;
   logic [PW-1:0] held_pos_y_q, held_pos_y_d;
   logic [VW-1:0] held_vel_x_q, held_vel_x_d;
   logic [VW-1:0] held_vel_y_q, held_vel_y_d;

   logic [PW-1:0] cur_pos_x, cur_pos_y;
   logic [VW-1:0] cur_vel_x, cur_vel_y;

   logic init_we, upd_we, expire, advance, driving;

   // The setup cycle after frame_start is IDLE with busy_q set; host writes are closed then too.
   assign init_we = init_valid_in && (state_q == S_IDLE) && !busy_q;
   assign upd_we  = (state_q == S_WAIT) && upd.result_in;
   assign advance = upd_we || expire;
   assign driving = (state_q == S_ISSUE) || (state_q == S_WAIT);

`ifdef SEQ_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;

   always_comb begin
      wait_cnt_d = '0;
      timeout_d  = timeout_q;
      expire     = 1'b0;
      if (state_q == S_WAIT) begin
         wait_cnt_d = wait_cnt_q + 1'b1;
         if (!upd.result_in && wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            expire    = 1'b1;
            timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign timeout_out = timeout_q;
`else
   assign expire      = 1'b0;
   assign timeout_out = 1'b0;
`endif

   always_comb begin
      cur_pos_x = '0;
      cur_pos_y = '0;
      cur_vel_x = '0;
      cur_vel_y = '0;
      rd_pos_x_out = '0;
      rd_pos_y_out = '0;
      // Out-of-range indices match no entry and therefore read as zero.
      for (int i = 0; i < NUM_POINTS; i++) begin
         if (idx_q == 8'(i)) begin
            cur_pos_x = pos_x_q[i];
            cur_pos_y = pos_y_q[i];
            cur_vel_x = vel_x_q[i];
            cur_vel_y = vel_y_q[i];
         end
         if (rd_idx_in == 8'(i)) begin
            rd_pos_x_out = pos_x_q[i];
            rd_pos_y_out = pos_y_q[i];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      busy_d       = busy_q;
      held_pos_x_d = held_pos_x_q;
      held_pos_y_d = held_pos_y_q;
      held_vel_x_d = held_vel_x_q;
      held_vel_y_d = held_vel_y_q;
      pos_x_d      = pos_x_q;
      pos_y_d      = pos_y_q;
      vel_x_d      = vel_x_q;
      vel_y_d      = vel_y_q;

      case (state_q)
         S_IDLE: begin
            if (busy_q) begin
               state_d = S_ISSUE;
            end else if (frame_start_in) begin
               busy_d = 1'b1;
               idx_d  = '0;
            end
         end
         S_ISSUE: begin
            state_d      = S_WAIT;
            held_pos_x_d = cur_pos_x;
            held_pos_y_d = cur_pos_y;
            held_vel_x_d = cur_vel_x;
            held_vel_y_d = cur_vel_y;
         end
         S_WAIT: begin
            if (advance) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
               end else begin
                  idx_d   = idx_q + 8'd1;
                  state_d = S_ISSUE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      for (int i = 0; i < NUM_POINTS; i++) begin
         if (init_we && init_idx_in == 8'(i)) begin
            pos_x_d[i] = init_pos_x_in;
            pos_y_d[i] = init_pos_y_in;
            vel_x_d[i] = init_vel_x_in;
            vel_y_d[i] = init_vel_y_in;
         end
         if (upd_we && idx_q == 8'(i)) begin
            pos_x_d[i] = upd.new_pos_x_in;
            pos_y_d[i] = upd.new_pos_y_in;
            vel_x_d[i] = upd.new_vel_x_in;
            vel_y_d[i] = upd.new_vel_y_in;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= S_IDLE;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         held_pos_x_q <= '0;
         held_pos_y_q <= '0;
         held_vel_x_q <= '0;
         held_vel_y_q <= '0;
         for (int i = 0; i < NUM_POINTS; i++) begin
            pos_x_q[i] <= '0;
            pos_y_q[i] <= '0;
            vel_x_q[i] <= '0;
            vel_y_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         busy_q       <= busy_d;
         held_pos_x_q <= held_pos_x_d;
         held_pos_y_q <= held_pos_y_d;
         held_vel_x_q <= held_vel_x_d;
         held_vel_y_q <= held_vel_y_d;
         for (int i = 0; i < NUM_POINTS; i++) begin
            pos_x_q[i] <= pos_x_d[i];
            pos_y_q[i] <= pos_y_d[i];
            vel_x_q[i] <= vel_x_d[i];
            vel_y_q[i] <= vel_y_d[i];
         end
      end
   end

   assign upd.begin_out = (state_q == S_ISSUE);
   assign upd.pos_x_out = driving ? cur_pos_x : held_pos_x_q;
   assign upd.pos_y_out = driving ? cur_pos_y : held_pos_y_q;
   assign upd.vel_x_out = driving ? cur_vel_x : held_vel_x_q;
   assign upd.vel_y_out = driving ? cur_vel_y : held_vel_y_q;

   assign busy_out       = busy_q;
   assign frame_done_out = (state_q == S_DONE);

endmodule

// File: tb/tb_point_sequencer.sv
// Scoreboard bench for point_sequencer: the bench plays update_point and checks issue order, latency and storage.
module tb_point_sequencer;
   localparam int NP = 4;
   localparam int PW = 8;
   localparam int VW = 8;
   localparam int TO = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_start = 1'b0;
   logic          init_valid = 1'b0;
   logic [7:0]    init_idx = '0;
   logic [PW-1:0] ipx = '0, ipy = '0;
   logic [VW-1:0] ivx = '0, ivy = '0;
   logic [7:0]    rd_idx = '0;
   logic [PW-1:0] rd_px, rd_py;
   logic          busy, done, tmo;

   point_sequencer_if #(.POSITION_SIZE(PW), .VELOCITY_SIZE(VW)) upd_if ();

   point_sequencer #(
      .NUM_POINTS(NP), .POSITION_SIZE(PW), .VELOCITY_SIZE(VW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_in(clk), .rst_in(rst), .frame_start_in(frame_start),
      .init_valid_in(init_valid), .init_idx_in(init_idx),
      .init_pos_x_in(ipx), .init_pos_y_in(ipy), .init_vel_x_in(ivx), .init_vel_y_in(ivy),
      .upd(upd_if), .rd_idx_in(rd_idx), .rd_pos_x_out(rd_px), .rd_pos_y_out(rd_py),
      .busy_out(busy), .frame_done_out(done), .timeout_out(tmo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         idx;
      logic [7:0] px, py, vx, vy;
   } issue_t;

   issue_t     exp_q[$];
   issue_t     last_issue;
   logic [7:0] m_px[NP], m_py[NP], m_vx[NP], m_vy[NP];
   bit         exp_tmo = 1'b0;
   int         checks = 0;
   int         errors = 0;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      frame_start = 1'b0;
      init_valid  = 1'b0;
      upd_if.result_in    = 1'b0;
      upd_if.new_pos_x_in = '0;
      upd_if.new_pos_y_in = '0;
      upd_if.new_vel_x_in = '0;
      upd_if.new_vel_y_in = '0;
   endtask

   task automatic check_store(input string tag);
      for (int i = 0; i < NP; i++) begin
         rd_idx = 8'(i);
         #1;
         checks++;
         if ({rd_px, rd_py} !== {m_px[i], m_py[i]}) begin
            errors++;
            $display("FAIL %s rd_pos[%0d]: got %h expected %h", tag, i, {rd_px, rd_py}, {m_px[i], m_py[i]});
         end
      end
      rd_idx = 8'd7;
      #1;
      checks++;
      if ({rd_px, rd_py} !== 16'h0000) begin
         errors++;
         $display("FAIL %s rd_pos[7]: got %h expected 0000", tag, {rd_px, rd_py});
      end
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      step();
      step();
      checks++;
      if ({upd_if.begin_out, busy, done, tmo} !== 4'b0000 ||
          {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out} !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ctl=%b data=%h expected 0",
                  {upd_if.begin_out, busy, done, tmo},
                  {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out});
      end
      for (int i = 0; i < NP; i++) begin
         m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
      end
      exp_tmo = 1'b0;
      check_store("reset");
      rst = 1'b0;
      step();
   endtask

   task automatic test_init_load();
      for (int i = 0; i < NP; i++) begin
         init_valid = 1'b1;
         init_idx   = 8'(i);
         if (i == NP - 1) begin
            ipx = 8'hFF; ipy = 8'h00; ivx = 8'h7F; ivy = 8'h80;
         end else begin
            ipx = 8'(16 * i + 3); ipy = 8'(200 - i); ivx = 8'(i + 1); ivy = 8'(250 - 7 * i);
         end
         m_px[i] = ipx; m_py[i] = ipy; m_vx[i] = ivx; m_vy[i] = ivy;
         step();
      end
      init_valid = 1'b0;
      check_store("init_load");
      checks++;
      if ({upd_if.pos_x_out, upd_if.vel_y_out, busy} !== 17'h0) begin
         errors++;
         $display("FAIL init_outputs_idle: got %h expected 0", {upd_if.pos_x_out, upd_if.vel_y_out, busy});
      end
   endtask

   // lat: WAIT cycles per point; skip_idx: point never answered; poke: stray inputs mid-frame;
   // co_init: an init write to point 2 in the same cycle as frame_start.
   task automatic run_frame(input int lat, input int skip_idx, input bit poke, input bit co_init,
                            input string tag);
      int     cyc;
      int     nbeg;
      int     cnt;
      int     exp_lat;
      bit     pending;
      bit     done_seen;
      issue_t cur;
      cyc = 0; nbeg = 0; cnt = 0; pending = 1'b0; done_seen = 1'b0; exp_lat = 2;
      cur = '{idx: -1, px: 8'h0, py: 8'h0, vx: 8'h0, vy: 8'h0};
      clear_inputs();
      if (co_init) begin
         init_valid = 1'b1; init_idx = 8'd2;
         ipx = 8'hA5; ipy = 8'h5A; ivx = 8'hC3; ivy = 8'h3C;
         m_px[2] = ipx; m_py[2] = ipy; m_vx[2] = ivx; m_vy[2] = ivy;
      end
      frame_start = 1'b1;
      for (int i = 0; i < NP; i++) begin
         exp_q.push_back('{idx: i, px: m_px[i], py: m_py[i], vx: m_vx[i], vy: m_vy[i]});
         exp_lat += 1 + ((i == skip_idx) ? TO : lat);
      end
      step();
      cyc = 1;
      clear_inputs();
      checks++;
      if ({busy, upd_if.begin_out} !== 2'b10) begin
         errors++;
         $display("FAIL %s setup_cycle busy/begin: got %b expected 10", tag, {busy, upd_if.begin_out});
      end
      while (cyc < 600 && !done_seen) begin
         clear_inputs();
         if (done) begin
            done_seen = 1'b1;
            checks++;
            if (cyc != exp_lat || busy !== 1'b0) begin
               errors++;
               $display("FAIL %s frame_done: got cycle %0d busy %b expected cycle %0d busy 0",
                        tag, cyc, busy, exp_lat);
            end
         end else if (upd_if.begin_out) begin
            nbeg++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL %s extra_begin: got begin at cycle %0d expected none", tag, cyc);
            end else begin
               cur = exp_q.pop_front();
               last_issue = cur;
               pending = 1'b1;
               cnt = 0;
               if ({upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out} !==
                   {cur.px, cur.py, cur.vx, cur.vy}) begin
                  errors++;
                  $display("FAIL %s issue[%0d]: got %h expected %h", tag, cur.idx,
                           {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out},
                           {cur.px, cur.py, cur.vx, cur.vy});
               end
               if (poke && cur.idx == 1) begin
                  upd_if.result_in = 1'b1;
                  upd_if.new_pos_x_in = 8'hEE; upd_if.new_pos_y_in = 8'hEE;
                  upd_if.new_vel_x_in = 8'hEE; upd_if.new_vel_y_in = 8'hEE;
               end
            end
         end else if (pending) begin
            cnt++;
            checks++;
            if (upd_if.begin_out !== 1'b0 || busy !== 1'b1 ||
                {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out} !==
                {cur.px, cur.py, cur.vx, cur.vy}) begin
               errors++;
               $display("FAIL %s wait_stable[%0d]: got begin %b busy %b data %h expected 0 1 %h",
                        tag, cur.idx, upd_if.begin_out, busy,
                        {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out},
                        {cur.px, cur.py, cur.vx, cur.vy});
            end
            if (cur.idx == skip_idx) begin
               if (cnt == TO) pending = 1'b0;
            end else if (cnt == lat) begin
               upd_if.result_in    = 1'b1;
               upd_if.new_pos_x_in = cur.px + 8'(cur.idx + 1);
               upd_if.new_pos_y_in = cur.py ^ 8'h3C;
               upd_if.new_vel_x_in = cur.vx - 8'd1;
               upd_if.new_vel_y_in = ~cur.vy;
               m_px[cur.idx] = upd_if.new_pos_x_in;
               m_py[cur.idx] = upd_if.new_pos_y_in;
               m_vx[cur.idx] = upd_if.new_vel_x_in;
               m_vy[cur.idx] = upd_if.new_vel_y_in;
               pending = 1'b0;
            end
         end
         if (poke && cyc == 4) begin
            frame_start = 1'b1;
            init_valid = 1'b1; init_idx = 8'd0;
            ipx = 8'h55; ipy = 8'h55; ivx = 8'h55; ivy = 8'h55;
         end
         step();
         cyc++;
      end
      clear_inputs();
      checks++;
      if (!done_seen || nbeg != NP || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s frame_summary: got done %0d begins %0d left %0d expected 1 %0d 0",
                  tag, done_seen, nbeg, exp_q.size(), NP);
      end
      exp_q.delete();
      checks++;
      if (tmo !== exp_tmo) begin
         errors++;
         $display("FAIL %s timeout_flag: got %b expected %b", tag, tmo, exp_tmo);
      end
      // Now in IDLE: outputs keep the last point sent.
      checks++;
      if ({upd_if.begin_out, busy, done} !== 3'b000 ||
          {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out} !==
          {last_issue.px, last_issue.py, last_issue.vx, last_issue.vy}) begin
         errors++;
         $display("FAIL %s idle_hold: got ctl %b data %h expected 000 %h", tag,
                  {upd_if.begin_out, busy, done},
                  {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out},
                  {last_issue.px, last_issue.py, last_issue.vx, last_issue.vy});
      end
      check_store(tag);
   endtask

   task automatic test_immediate_result();
      run_frame(1, -1, 1'b0, 1'b0, "immediate");
   endtask

   task automatic test_latency3();
      run_frame(3, -1, 1'b0, 1'b0, "latency3");
   endtask

   task automatic test_ignored_inputs();
      run_frame(2, -1, 1'b1, 1'b0, "midframe_poke");
      for (int c = 0; c < 4; c++) begin
         upd_if.result_in = 1'b1;
         upd_if.new_pos_x_in = 8'h99; upd_if.new_pos_y_in = 8'h99;
         upd_if.new_vel_x_in = 8'h99; upd_if.new_vel_y_in = 8'h99;
         init_valid = (c >= 2);
         init_idx = 8'd7;
         ipx = 8'h77; ipy = 8'h77; ivx = 8'h77; ivy = 8'h77;
         step();
         checks++;
         if ({upd_if.begin_out, busy} !== 2'b00) begin
            errors++;
            $display("FAIL idle_ignore[%0d]: got begin/busy %b expected 00", c, {upd_if.begin_out, busy});
         end
      end
      clear_inputs();
      check_store("idle_ignore");
   endtask

   task automatic test_back_to_back();
      run_frame(1, -1, 1'b0, 1'b1, "co_init");
      run_frame(2, -1, 1'b0, 1'b0, "back_to_back");
   endtask

   task automatic test_reset_mid_frame();
      int nb;
      bit got;
      bit rsp;
      nb = 0; got = 1'b0; rsp = 1'b0;
      clear_inputs();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         upd_if.result_in = rsp;
         rsp = 1'b0;
         if (upd_if.begin_out) begin
            nb++;
            if (nb < 3) rsp = 1'b1;
            else got = 1'b1;
         end
         step();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL reset_mid_frame: got %0d begins expected 3", nb);
      end
      rst = 1'b1;
      upd_if.result_in = 1'b1;
      upd_if.new_pos_x_in = 8'h44; upd_if.new_pos_y_in = 8'h44;
      upd_if.new_vel_x_in = 8'h44; upd_if.new_vel_y_in = 8'h44;
      step();
      checks++;
      if ({upd_if.begin_out, busy, done, tmo} !== 4'b0000 ||
          {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out} !== 32'h0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got ctl=%b data=%h expected 0",
                  {upd_if.begin_out, busy, done, tmo},
                  {upd_if.pos_x_out, upd_if.pos_y_out, upd_if.vel_x_out, upd_if.vel_y_out});
      end
      for (int i = 0; i < NP; i++) begin
         m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
      end
      exp_tmo = 1'b0;
      check_store("reset_mid");
      rst = 1'b0;
      clear_inputs();
      step();
   endtask

   task automatic test_timeout();
`ifdef SEQ_TIMEOUT_EN
      exp_tmo = 1'b1;
      run_frame(1, 1, 1'b0, 1'b0, "timeout");
      run_frame(1, -1, 1'b0, 1'b0, "timeout_sticky");
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (tmo !== 1'b0) begin
         errors++;
         $display("FAIL timeout_reset: got %b expected 0", tmo);
      end
      exp_tmo = 1'b0;
      for (int i = 0; i < NP; i++) begin
         m_px[i] = '0; m_py[i] = '0; m_vx[i] = '0; m_vy[i] = '0;
      end
      step();
`else
      run_frame(4, -1, 1'b0, 1'b0, "no_timeout_flag");
`endif
   endtask

   initial begin
      test_reset();
      test_init_load();
      test_immediate_result();
      test_latency3();
      test_ignored_inputs();
      test_back_to_back();
      test_reset_mid_frame();
      test_init_load();
      test_timeout();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
